// File: rtl/ring_osc_pkg.sv
// Shared types and constants for the tapped ring oscillator sweeper.
// The state encoding is fixed at 3 bits so that readout logic can decode it directly.
package ring_osc_pkg;

  localparam int TAP_W    = 4;
  localparam int NUM_TAPS = 16;

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_FLUSH   = 3'd1,
    S_SETTLE  = 3'd2,
    S_MEASURE = 3'd3,
    S_REPORT  = 3'd4
  } state_t;

  // Out-of-range tap indices saturate at the highest physical tap.
  function automatic logic [TAP_W-1:0] clamp_tap(input int tap);
    if (tap > NUM_TAPS - 1) begin
      clamp_tap = TAP_W'(NUM_TAPS - 1);
    end else begin
      clamp_tap = TAP_W'(tap);
    end
  endfunction

endpackage

// File: rtl/ring_tap_sweeper_if.sv
// Result channel from the sweeper to the VGA/readout logic.
// A result transfers on any cycle where res_valid and res_ready are both high.
interface ring_tap_sweeper_if
  import ring_osc_pkg::*;
#(
  parameter int COUNT_W = 16
);
  logic               res_valid;
  logic               res_ready;
  logic [TAP_W-1:0]   res_tap;
  logic [COUNT_W-1:0] res_count;

  modport master (
    output res_valid,
    output res_tap,
    output res_count,
    input  res_ready
  );

  modport slave (
    input  res_valid,
    input  res_tap,
    input  res_count,
    output res_ready
  );
endinterface

// File: rtl/edge_sync_counter.sv
// Synchronises the asynchronous ring_div input and counts its rising edges.
// count_next includes an edge seen this cycle so the caller can capture a final value.
module edge_sync_counter #(
  parameter int COUNT_W = 16
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               ring_div,
  input  logic               clr,
  input  logic               en,
  output logic [COUNT_W-1:0] count_next
);
  localparam logic [COUNT_W-1:0] COUNT_MAX = {COUNT_W{1'b1}};
  localparam logic [COUNT_W-1:0] COUNT_ONE = {{(COUNT_W-1){1'b0}}, 1'b1};

  logic [2:0]         sync_r;
  logic               rise_s;
  logic [COUNT_W-1:0] count_r;
  logic [COUNT_W-1:0] count_next_s;

  // sync_r[1] is the second synchroniser stage, sync_r[2] the edge-detect history.
  assign rise_s = sync_r[1] & ~sync_r[2];

  // Saturating increment on each detected edge while enabled.
  always_comb begin
    count_next_s = count_r;
    if (en && rise_s && (count_r != COUNT_MAX)) begin
      count_next_s = count_r + COUNT_ONE;
    end else begin
      count_next_s = count_r;
    end
  end

  // Synchroniser shift chain and counter state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_r  <= 3'b000;
      count_r <= {COUNT_W{1'b0}};
    end else begin
      sync_r <= {sync_r[1:0], ring_div};
      if (clr) begin
        count_r <= {COUNT_W{1'b0}};
      end else begin
        count_r <= count_next_s;
      end
    end
  end

  assign count_next = count_next_s;

endmodule

// File: rtl/ring_tap_sweeper.sv
// Sequences the tapped ring oscillator: flush, settle, gated edge count, report.
// In sweep mode it steps taps 0..LAST_TAP; results leave over a valid/ready channel.
module ring_tap_sweeper
  import ring_osc_pkg::*;
#(
  parameter int FLUSH_CYCLES  = 16,
  parameter int SETTLE_CYCLES = 64,
  parameter int GATE_CYCLES   = 4096,
  parameter int COUNT_W       = 16,
  parameter int LAST_TAP      = 13
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             sweep,
  input  logic [TAP_W-1:0] tap_req,
  input  logic             abort,
  input  logic             ring_div,
  output logic             ring_ena,
  output logic [TAP_W-1:0] ring_tap,
  output logic             busy,
  ring_tap_sweeper_if.master res
);
  localparam int MAX_FS     = (FLUSH_CYCLES > SETTLE_CYCLES) ? FLUSH_CYCLES : SETTLE_CYCLES;
  localparam int MAX_CYCLES = (MAX_FS > GATE_CYCLES) ? MAX_FS : GATE_CYCLES;
  localparam int PH_W       = (MAX_CYCLES > 1) ? $clog2(MAX_CYCLES) : 1;

  localparam logic [PH_W-1:0]  FLUSH_LD  = PH_W'(FLUSH_CYCLES - 1);
  localparam logic [PH_W-1:0]  SETTLE_LD = PH_W'(SETTLE_CYCLES - 1);
  localparam logic [PH_W-1:0]  GATE_LD   = PH_W'(GATE_CYCLES - 1);
  localparam logic [PH_W-1:0]  PH_ONE    = {{(PH_W-1){1'b0}}, 1'b1};
  localparam logic [TAP_W-1:0] LAST_T    = clamp_tap(LAST_TAP);

  state_t             state_r;
  state_t             state_n;
  logic [PH_W-1:0]    phase_r;
  logic               phase_done_s;
  logic               meas_done_s;
  logic               sweep_r;
  logic               ring_ena_r;
  logic [TAP_W-1:0]   ring_tap_r;
  logic               busy_r;
  logic               res_valid_r;
  logic [TAP_W-1:0]   res_tap_r;
  logic [COUNT_W-1:0] res_count_r;
  logic [COUNT_W-1:0] cnt_next_s;
  logic               cnt_en_s;
  logic               cnt_clr_s;

  assign phase_done_s = (phase_r == {PH_W{1'b0}});
  assign cnt_en_s     = (state_r == S_MEASURE);
  assign cnt_clr_s    = (state_r != S_MEASURE);
  assign meas_done_s  = (state_r == S_MEASURE) && (state_n == S_REPORT);

  edge_sync_counter #(
    .COUNT_W (COUNT_W)
  ) u_counter (
    .clk        (clk),
    .rst_n      (rst_n),
    .ring_div   (ring_div),
    .clr        (cnt_clr_s),
    .en         (cnt_en_s),
    .count_next (cnt_next_s)
  );

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= S_IDLE;
    end else begin
      state_r <= state_n;
    end
  end

  // Next-state logic; abort overrides every busy state, and beats start in IDLE.
  always_comb begin
    state_n = state_r;
    if ((state_r != S_IDLE) && abort) begin
      state_n = S_IDLE;
    end else begin
      case (state_r)
        S_IDLE: begin
          if (start && !abort) state_n = S_FLUSH;
          else                 state_n = S_IDLE;
        end
        S_FLUSH: begin
          if (phase_done_s) state_n = S_SETTLE;
          else              state_n = S_FLUSH;
        end
        S_SETTLE: begin
          if (phase_done_s) state_n = S_MEASURE;
          else              state_n = S_SETTLE;
        end
        S_MEASURE: begin
          if (phase_done_s) state_n = S_REPORT;
          else              state_n = S_MEASURE;
        end
        S_REPORT: begin
          if (res_ready_accept()) begin
            if (sweep_r && (ring_tap_r < LAST_T)) state_n = S_FLUSH;
            else                                  state_n = S_IDLE;
          end else begin
            state_n = S_REPORT;
          end
        end
        default: state_n = S_IDLE;
      endcase
    end
  end

  function automatic logic res_ready_accept();
    res_ready_accept = res_valid_r && res.res_ready;
  endfunction

  // Shared phase down-counter, reloaded with the length of each timed state on entry.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      phase_r <= {PH_W{1'b0}};
    end else if (state_n != state_r) begin
      case (state_n)
        S_FLUSH:   phase_r <= FLUSH_LD;
        S_SETTLE:  phase_r <= SETTLE_LD;
        S_MEASURE: phase_r <= GATE_LD;
        default:   phase_r <= {PH_W{1'b0}};
      endcase
    end else if (!phase_done_s) begin
      phase_r <= phase_r - PH_ONE;
    end
  end

  // Registered outputs derived from the upcoming state; the tap only moves while the ring is off.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sweep_r     <= 1'b0;
      ring_ena_r  <= 1'b0;
      ring_tap_r  <= {TAP_W{1'b0}};
      busy_r      <= 1'b0;
      res_valid_r <= 1'b0;
      res_tap_r   <= {TAP_W{1'b0}};
      res_count_r <= {COUNT_W{1'b0}};
    end else begin
      ring_ena_r <= (state_n == S_SETTLE) || (state_n == S_MEASURE);
      busy_r     <= (state_n != S_IDLE);
      if ((state_r == S_IDLE) && (state_n == S_FLUSH)) begin
        sweep_r    <= sweep;
        ring_tap_r <= sweep ? {TAP_W{1'b0}} : tap_req;
      end else if ((state_r == S_REPORT) && (state_n == S_FLUSH)) begin
        ring_tap_r <= ring_tap_r + {{(TAP_W-1){1'b0}}, 1'b1};
      end
      if (meas_done_s) begin
        res_valid_r <= 1'b1;
        res_tap_r   <= ring_tap_r;
        res_count_r <= cnt_next_s;
      end else if (state_n != S_REPORT) begin
        res_valid_r <= 1'b0;
      end
    end
  end

  assign ring_ena      = ring_ena_r;
  assign ring_tap      = ring_tap_r;
  assign busy          = busy_r;
  assign res.res_valid = res_valid_r;
  assign res.res_tap   = res_tap_r;
  assign res.res_count = res_count_r;

endmodule
